// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: walks a {register, value} ROM and issues one SCCB write per entry.
// Optional macro CFG_AUTOSTART_EN: fire one implicit pass on the first clk edge after rst deasserts.
module ov7670_config_sequencer #(
    parameter int CAMERA_FREQ  = 25_000_000,
    parameter int DELAY_CYCLES = CAMERA_FREQ / 100,
    parameter int ROM_DEPTH    = 64,
    localparam int IW = $clog2(ROM_DEPTH),
    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic          sccb_ready,
    output logic          sccb_start,
    output logic [7:0]    sccb_address,
    output logic [7:0]    sccb_data,
    output logic          cfg_busy,
    output logic          cfg_done,
    output logic [IW-1:0] cfg_index
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT_IDLE, WAIT_ACCEPT, WAIT_DONE, DELAY, DONE} state_t;
    state_t          state;
    logic [15:0]     rom_word;
    logic [DW-1:0]   delay_cnt;
    logic            go;
    logic            last;
    // OV7670 RGB565 bring-up table: FFF0 = settle delay, FFFF = end of table
    function automatic logic [15:0] rom(input logic [IW-1:0] i);
        case (int'(i))
            0:  return 16'h1280;
            1:  return 16'hFFF0;
            2:  return 16'h1204;
            3:  return 16'h1100;
            4:  return 16'h0C00;
            5:  return 16'h3E00;
            6:  return 16'h8C00;
            7:  return 16'h40D0;
            8:  return 16'h3A04;
            9:  return 16'h1438;
            10: return 16'h4FB3;
            11: return 16'h50B3;
            12: return 16'h5100;
            13: return 16'h523D;
            14: return 16'h53A7;
            15: return 16'h54E4;
            16: return 16'h589E;
            17: return 16'h3DC0;
            18: return 16'h1714;
            19: return 16'h1802;
            20: return 16'h3280;
            21: return 16'h1903;
            22: return 16'h1A7B;
            23: return 16'h030A;
            24: return 16'hFFF0;
            25: return 16'h1500;
            default: return 16'hFFFF;
        endcase
    endfunction
    // the last reachable entry doubles as an end marker so the index never wraps mid-pass
    assign last = (cfg_index == IW'(ROM_DEPTH - 1));
`ifdef CFG_AUTOSTART_EN
    logic auto_pend;
    // one-shot that stands in for cfg_start on the first edge out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) auto_pend <= 1'b1;
        else auto_pend <= 1'b0;
    end
    assign go = cfg_start | auto_pend;
`else
    assign go = cfg_start;
`endif
    // sequencer FSM with registered SCCB request and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rom_word     <= '0;
            delay_cnt    <= '0;
            sccb_start   <= 1'b0;
            sccb_address <= '0;
            sccb_data    <= '0;
            cfg_busy     <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_index    <= '0;
        end else begin
            sccb_start <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    cfg_index <= '0;
                    cfg_done  <= 1'b0;
                    cfg_busy  <= 1'b1;
                    state     <= FETCH;
                end
                FETCH: begin
                    rom_word <= rom(cfg_index);
                    state    <= DECODE;
                end
                DECODE: if (rom_word == 16'hFFFF || last) state <= DONE;
                else if (rom_word == 16'hFFF0) begin
                    delay_cnt <= DW'(DELAY_CYCLES - 1);
                    state     <= DELAY;
                end else begin
                    {sccb_address, sccb_data} <= rom_word;
                    state <= WAIT_IDLE;
                end
                WAIT_IDLE: if (sccb_ready) begin
                    sccb_start <= 1'b1;
                    state      <= WAIT_ACCEPT;
                end
                WAIT_ACCEPT: if (!sccb_ready) state <= WAIT_DONE;
                WAIT_DONE: if (sccb_ready) begin
                    cfg_index <= cfg_index + 1'b1;
                    state     <= FETCH;
                end
                DELAY: if (delay_cnt == '0) begin
                    cfg_index <= cfg_index + 1'b1;
                    state     <= FETCH;
                end else delay_cnt <= delay_cnt - 1'b1;
                DONE: begin
                    cfg_busy <= 1'b0;
                    cfg_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb_ov7670_config_sequencer: randomized checks of the config sequencer against a table-walk model.
module tb_ov7670_config_sequencer;
    localparam int D = 8;
    localparam int ENG_BUSY = 20;
    localparam int ROM_N = 27;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, hold_a = 1'b0, ready_a, sccb_start_a, busy_a, done_a;
    logic [7:0] addr_a, data_a;
    logic [5:0] idx_a;
    logic start_b = 1'b0, ready_b, sccb_start_b, busy_b, done_b;
    logic [7:0] addr_b, data_b;
    logic [1:0] idx_b;
    int cyc = 0, eng_a = 0, eng_b = 0, rel_cyc = 0;
    int vectors = 0, miscompares = 0;
    logic [15:0] obs_w[$], obs_bw[$];
    int obs_t[$], obs_bt[$];
    int back_a = 0, back_b = 0;
    logic [5:0] pidx_a = '0;
    logic [1:0] pidx_b = '0;
    logic pbusy_a = 1'b0, pbusy_b = 1'b0;
    logic [15:0] exp_w[$];
    int exp_g[$];
    int exp_end;
    // the camera bring-up table as the sequencer is expected to walk it
    logic [15:0] ref_rom [ROM_N] = '{16'h1280, 16'hFFF0, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00, 16'h8C00,
        16'h40D0, 16'h3A04, 16'h1438, 16'h4FB3, 16'h50B3, 16'h5100, 16'h523D, 16'h53A7, 16'h54E4, 16'h589E,
        16'h3DC0, 16'h1714, 16'h1802, 16'h3280, 16'h1903, 16'h1A7B, 16'h030A, 16'hFFF0, 16'h1500, 16'hFFFF};

    ov7670_config_sequencer #(.DELAY_CYCLES(D), .ROM_DEPTH(64)) u_dut (
        .clk(clk), .rst(rst), .cfg_start(start_a), .sccb_ready(ready_a), .sccb_start(sccb_start_a),
        .sccb_address(addr_a), .sccb_data(data_a), .cfg_busy(busy_a), .cfg_done(done_a), .cfg_index(idx_a));
    ov7670_config_sequencer #(.DELAY_CYCLES(D), .ROM_DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .cfg_start(start_b), .sccb_ready(ready_b), .sccb_start(sccb_start_b),
        .sccb_address(addr_b), .sccb_data(data_b), .cfg_busy(busy_b), .cfg_done(done_b), .cfg_index(idx_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SCCB engine stand-in: ready drops for ENG_BUSY cycles after each accepted request
    always @(posedge clk) begin
        if (sccb_start_a) eng_a <= ENG_BUSY; else if (eng_a > 0) eng_a <= eng_a - 1;
        if (sccb_start_b) eng_b <= ENG_BUSY; else if (eng_b > 0) eng_b <= eng_b - 1;
    end
    assign ready_a = (eng_a == 0) && !hold_a;
    assign ready_b = (eng_b == 0);

    // record every request and flag any backwards index step inside a pass
    always @(negedge clk) begin
        if (sccb_start_a) begin obs_w.push_back({addr_a, data_a}); obs_t.push_back(cyc); end
        if (sccb_start_b) begin obs_bw.push_back({addr_b, data_b}); obs_bt.push_back(cyc); end
        if (busy_a && pbusy_a && idx_a < pidx_a) back_a <= back_a + 1;
        if (busy_b && pbusy_b && idx_b < pidx_b) back_b <= back_b + 1;
        pidx_a <= idx_a; pbusy_a <= busy_a;
        pidx_b <= idx_b; pbusy_b <= busy_b;
    end

    // expected writes, their spacing and final index from a plain walk of the table
    task automatic build_expected(input int depth);
        int k;
        logic [15:0] e;
        exp_w.delete(); exp_g.delete(); k = 0; exp_end = depth - 1;
        for (int i = 0; i < depth; i++) begin
            e = (i < ROM_N) ? ref_rom[i] : 16'hFFFF;
            if (e == 16'hFFFF || i == depth - 1) begin exp_end = i; break; end
            if (e == 16'hFFF0) k++;
            else begin exp_g.push_back(ENG_BUSY + 5 + k * (D + 2)); exp_w.push_back(e); k = 0; end
        end
    endtask

    task automatic release_reset;
        @(negedge clk); rst = 1'b0; rel_cyc = cyc;
`ifdef CFG_AUTOSTART_EN
        begin
            int n;
            n = 0;
            while (!(done_a && done_b) && n < 5000) begin @(negedge clk); n++; end
        end
`endif
    endtask

    // mode 0 plain, 1 ready held low at start, 2 random cfg_start pulses while busy
    task automatic run_pass(input int mode, input int first_at, input string tag);
        int t0, fa, n, b, nb;
        b = obs_w.size(); nb = back_a;
        build_expected(64);
        @(negedge clk);
        if (mode == 1) hold_a = 1'b1;
        start_a = 1'b1; t0 = cyc; fa = (t0 + 4 > first_at) ? t0 + 4 : first_at;
        @(negedge clk); start_a = 1'b0;
        if (mode == 1) begin
            repeat ($urandom_range(60, 10)) @(negedge clk);
            vectors++;
            if (obs_w.size() != b) begin
                miscompares++; $display("FAIL %s held_ready: got %0d requests, expected 0", tag, obs_w.size() - b);
            end
            hold_a = 1'b0; fa = cyc + 1;
        end
        n = 0;
        while (!done_a && n < 5000) begin
            @(negedge clk); n++;
            start_a = (mode == 2 && busy_a && $urandom_range(7, 0) == 0);
        end
        start_a = 1'b0;
        #1;
        vectors++;
        if (n >= 5000 || done_a !== 1'b1 || busy_a !== 1'b0) begin
            miscompares++; $display("FAIL %s end_status: got done=%b busy=%b, expected done=1 busy=0", tag, done_a, busy_a);
        end
        vectors++;
        if (obs_w.size() - b != exp_w.size()) begin
            miscompares++; $display("FAIL %s count: got %0d requests, expected %0d", tag, obs_w.size() - b, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && b + i < obs_w.size(); i++) begin
            vectors++;
            if (obs_w[b + i] !== exp_w[i]) begin
                miscompares++; $display("FAIL %s word%0d: got %h expected %h", tag, i, obs_w[b + i], exp_w[i]);
            end
            vectors++;
            if (obs_t[b + i] != (i == 0 ? fa : obs_t[b + i - 1] + exp_g[i])) begin
                miscompares++;
                $display("FAIL %s time%0d: got cycle %0d expected %0d", tag, i, obs_t[b + i], i == 0 ? fa : obs_t[b + i - 1] + exp_g[i]);
            end
        end
        vectors++;
        if (idx_a !== 6'(exp_end)) begin
            miscompares++; $display("FAIL %s end_index: got %0d expected %0d", tag, idx_a, exp_end);
        end
        vectors++;
        if (back_a != nb) begin
            miscompares++; $display("FAIL %s index_wrap: got %0d backward steps, expected 0", tag, back_a - nb);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({sccb_start_a, addr_a, data_a, busy_a, done_a, idx_a} !== '0) begin
            miscompares++; $display("FAIL reset_a: got %h expected 0", {sccb_start_a, addr_a, data_a, busy_a, done_a, idx_a});
        end
        vectors++;
        if ({sccb_start_b, addr_b, data_b, busy_b, done_b, idx_b} !== '0) begin
            miscompares++; $display("FAIL reset_b: got %h expected 0", {sccb_start_b, addr_b, data_b, busy_b, done_b, idx_b});
        end
        @(negedge clk); rst = 1'b0; rel_cyc = cyc;
    endtask

    task automatic test_autostart;
        int n;
        n = 0;
`ifdef CFG_AUTOSTART_EN
        while (obs_w.size() == 0 && n < 50) begin @(negedge clk); n++; end
        #1;
        vectors++;
        if (obs_w.size() == 0 || obs_t[0] != rel_cyc + 4 || obs_w[0] !== 16'h1280) begin
            miscompares++; $display("FAIL autostart: got %0d requests, first at %0d, expected 1280 at %0d",
                obs_w.size(), obs_w.size() ? obs_t[0] : -1, rel_cyc + 4);
        end
        n = 0;
        while (!(done_a && done_b) && n < 5000) begin @(negedge clk); n++; end
`else
        repeat (1000) @(negedge clk);
        n = obs_w.size() + obs_bw.size();
`endif
        vectors++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            miscompares++; $display("FAIL autostart_idle: got busy=%b%b expected 00", busy_a, busy_b);
        end
`ifndef CFG_AUTOSTART_EN
        vectors++;
        if (n != 0) begin
            miscompares++; $display("FAIL no_autostart: got %0d requests, expected 0", n);
        end
`endif
    endtask

    task automatic test_basic_pass;
        run_pass(0, 0, "basic");
    endtask

    task automatic test_ready_held;
        run_pass(1, 0, "held");
    endtask

    task automatic test_start_while_busy;
        repeat (2) run_pass(2, 0, "busy_start");
    endtask

    task automatic test_reset_in_delay;
        int b, n, t, k;
        b = obs_w.size();
        @(negedge clk); start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        n = 0;
        while (obs_w.size() == b && n < 100) begin @(negedge clk); n++; end
        #1;
        vectors++;
        if (obs_w.size() == b) begin
            miscompares++; $display("FAIL delay_reset_first: got no request, expected one"); return;
        end
        t = obs_t[b]; k = $urandom_range(31, 24);
        while (cyc < t + k) begin @(posedge clk); #1; end
        vectors++;
        if (busy_a !== 1'b1 || idx_a !== 6'd1 || sccb_start_a !== 1'b0) begin
            miscompares++; $display("FAIL in_delay: got busy=%b idx=%0d start=%b expected 1 1 0", busy_a, idx_a, sccb_start_a);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({sccb_start_a, addr_a, data_a, busy_a, done_a, idx_a} !== '0) begin
            miscompares++; $display("FAIL delay_reset: got %h expected 0", {sccb_start_a, addr_a, data_a, busy_a, done_a, idx_a});
        end
        release_reset();
        run_pass(0, 0, "after_delay_reset");
    endtask

    task automatic test_reset_mid_transaction;
        int b, n, t;
        b = obs_w.size();
        @(negedge clk); start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        n = 0;
        while (obs_w.size() == b && n < 100) begin @(negedge clk); n++; end
        #1;
        vectors++;
        if (obs_w.size() == b) begin
            miscompares++; $display("FAIL xact_reset_first: got no request, expected one"); return;
        end
        t = obs_t[b];
        while (cyc < t + int'($urandom_range(15, 2))) begin @(posedge clk); #1; end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({sccb_start_a, busy_a, done_a, idx_a} !== '0) begin
            miscompares++; $display("FAIL xact_reset: got %h expected 0", {sccb_start_a, busy_a, done_a, idx_a});
        end
        release_reset();
        run_pass(0, t + ENG_BUSY + 2, "after_xact_reset");
    endtask

    task automatic test_no_end_marker;
        int b, n, nb, t0;
        build_expected(4);
        b = obs_bw.size(); nb = back_b;
        @(negedge clk); start_b = 1'b1; t0 = cyc; @(negedge clk); start_b = 1'b0;
        n = 0;
        while (!done_b && n < 2000) begin @(negedge clk); n++; end
        #1;
        vectors++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || idx_b !== 2'(exp_end)) begin
            miscompares++; $display("FAIL no_end: got done=%b busy=%b idx=%0d expected 1 0 %0d", done_b, busy_b, idx_b, exp_end);
        end
        vectors++;
        if (obs_bw.size() - b != exp_w.size()) begin
            miscompares++; $display("FAIL no_end count: got %0d expected %0d", obs_bw.size() - b, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && b + i < obs_bw.size(); i++) begin
            vectors++;
            if (obs_bw[b + i] !== exp_w[i] || (i == 0 && obs_bt[b] != t0 + 4)) begin
                miscompares++; $display("FAIL no_end word%0d: got %h expected %h", i, obs_bw[b + i], exp_w[i]);
            end
        end
        vectors++;
        if (back_b != nb) begin
            miscompares++; $display("FAIL no_end wrap: got %0d backward steps expected 0", back_b - nb);
        end
    endtask

    initial begin
        test_reset();
        test_autostart();
        test_basic_pass();
        test_ready_held();
        test_start_while_busy();
        test_reset_in_delay();
        test_reset_mid_transaction();
        test_no_end_marker();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ov7670_config_sequencer.md
Name: ov7670_config_sequencer

Overview:
- Upstream of the SCCB write engine: walks an internal ROM of {register, value} pairs and issues one SCCB write per entry.
- Honours delay markers in the ROM, such as the settle time after the camera soft reset.
- Signals completion to the capture pipeline.
- Runs once per trigger, entirely in the camera clock domain.

Parameters:
- CAMERA_FREQ, 25_000_000: clock frequency in Hz.
- DELAY_CYCLES, CAMERA_FREQ/100: cycles waited per delay marker (10 ms by default).
- ROM_DEPTH, 64: number of ROM entries; the index width is clog2(ROM_DEPTH).

Ports:
- clk  in  1: camera clock.
- rst  in  1: reset.
- cfg_start  in  1: single-cycle pulse that begins a configuration pass.
- sccb_ready  in  1: ready from the SCCB engine; high = idle.
- sccb_start  out  1: single-cycle write request to the SCCB engine.
- sccb_address  out  8: camera register address.
- sccb_data  out  8: register value.
- cfg_busy  out  1: high while a pass is in progress.
- cfg_done  out  1: sticky flag; set when the end marker is reached, cleared by cfg_start or rst.
- cfg_index  out  clog2(ROM_DEPTH): index of the current ROM entry (debug).

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; sccb_start 0; sccb_address 0; sccb_data 0; cfg_busy 0; cfg_done 0; cfg_index 0; delay counter 0.
- ROM: combinational function of index, 16 bits wide, {addr[15:8], data[7:0]}.
  - Markers: 16'hFFFF = end; 16'hFFF0 = delay DELAY_CYCLES.
  - Mandatory contents: entry 0 = 16'h1280 (COM7 soft reset); entry 1 = 16'hFFF0; entry 2 = 16'h1204 (RGB output).
  - Remaining entries are design-specific. The last used entry is 16'hFFFF.
  - Unused indices return 16'hFFFF.
- States:
  - IDLE: on cfg_start, set cfg_index=0, cfg_done=0, cfg_busy=1, go to FETCH. Otherwise stay.
  - FETCH: register the ROM word, go to DECODE (1 cycle).
  - DECODE: end marker -> DONE. Delay marker -> load counter with DELAY_CYCLES-1, go to DELAY. Otherwise drive sccb_address/sccb_data and go to WAIT_IDLE.
  - WAIT_IDLE: hold until sccb_ready=1, then assert sccb_start for exactly one cycle and go to WAIT_ACCEPT.
  - WAIT_ACCEPT: hold until sccb_ready=0 (the engine latched the request), then go to WAIT_DONE. sccb_start stays 0.
  - WAIT_DONE: hold until sccb_ready=1, then cfg_index+1 and go to FETCH.
  - DELAY: decrement each cycle. At 0, cfg_index+1 and go to FETCH. Total time in DELAY is exactly DELAY_CYCLES cycles.
  - DONE: cfg_busy=0, cfg_done=1, go to IDLE.
- sccb_address/sccb_data are stable from DECODE until the next DECODE, so they are valid whenever sccb_start is high.
- Minimum latency: cfg_start to first sccb_start = 4 cycles when sccb_ready=1 (IDLE->FETCH->DECODE->WAIT_IDLE->start).
- Index wrap: if cfg_index reaches ROM_DEPTH-1 without an end marker, that entry is treated as the end marker. The index never wraps to 0 mid-pass.
- cfg_start while busy: ignored (no restart, no glitch on the SCCB outputs).
- Reset mid-operation: all state returns to reset values at once. An SCCB transaction already launched is not aborted by this block; the next pass waits for sccb_ready.
- Simultaneous cfg_start and rst: rst wins.

Optional Feature:
- Macro: CFG_AUTOSTART_EN.
- Defined: an internal one-shot fires an implicit cfg_start on the first clk edge after rst deasserts, so configuration needs no external trigger. cfg_start still works for later passes.
- Undefined: only cfg_start begins a pass.

Test Plan:
- Run with DELAY_CYCLES=8 and sccb_ready modelled as 0 for 20 cycles after each sccb_start.
  - Stimulus: cfg_start pulse.
  - Required: first sccb_start carries address 0x12 / data 0x80.
  - Required: then exactly 8 idle cycles in DELAY, then the next request carries 0x12 / 0x04.
  - Required: after the end marker, cfg_done=1 and cfg_busy=0, and the number of sccb_start pulses equals the number of non-marker entries.
- Hold sccb_ready=0 at cfg_start -> no sccb_start until ready rises. When it rises, exactly one sccb_start pulse follows.
- Pulse cfg_start again while cfg_busy=1 -> cfg_index and the request sequence are unaffected.
- Assert rst during DELAY -> all outputs return to 0 the same cycle. A fresh cfg_start restarts at index 0 with 0x12 / 0x80.
- Build with CFG_AUTOSTART_EN defined and no cfg_start -> first sccb_start after 4 cycles past rst deassertion. Build without it -> no sccb_start for 1000 cycles.
- Force a ROM with no end marker (ROM_DEPTH=4) -> pass terminates at index 3 with cfg_done=1 and no index wrap.
